// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between the instruction-fetch (i_*) and data (d_*) requesters.
// Latency : memory command registered 1 cycle after the request is seen in IDLE; resp is combinational.
// Backpr. : requesters hold read/write level until their resp; the loser waits in place, nothing is queued.
//
// Ports
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   i_read/i_write/i_byte_enable/i_addr/i_wdata -> instruction-side request
//   i_rdata/i_resp                <- instruction-side read data and 1-cycle completion pulse
//   d_*                           same as i_*, data side
//   mem_read/mem_write/mem_byte_enable/mem_addr/mem_wdata -> registered memory command
//   mem_rdata/mem_resp            <- memory read data and 1-cycle completion pulse
//
// Build option
//   ARB_RR_EN : when defined, ties alternate between the two sides through a last-grant bit.
//               When undefined, the data side always wins a tie.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [DATA_W/8-1:0]   i_byte_enable,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_W/8-1:0]   d_byte_enable,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                req_i, req_d;
    logic                pick_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

`ifdef ARB_RR_EN
    // 1 = data side was granted last; reset points at the instruction side
    // so the first tie goes to data.
    logic last_grant_d_q, last_grant_d_d;

    assign pick_d = req_d & (~req_i | ~last_grant_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d_q <= 1'b0;
        end else begin
            last_grant_d_q <= last_grant_d_d;
        end
    end
`else
    // Fixed priority: data wins every tie. Fetch may starve under continuous
    // data traffic, which the pipeline tolerates because it stalls fetch then.
    assign pick_d = req_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_RR_EN
        last_grant_d_d = last_grant_d_q;
`endif

        unique case (state_q)
            IDLE: begin
                // Read and write together is illegal; write takes precedence.
                if (pick_d) begin
                    state_d     = SERVE_D;
                    mem_write_d = d_write;
                    mem_read_d  = d_read & ~d_write;
                    mem_be_d    = d_byte_enable;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
`ifdef ARB_RR_EN
                    last_grant_d_d = 1'b1;
`endif
                end else if (req_i) begin
                    state_d     = SERVE_I;
                    mem_write_d = i_write;
                    mem_read_d  = i_read & ~i_write;
                    mem_be_d    = i_byte_enable;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = i_wdata;
`ifdef ARB_RR_EN
                    last_grant_d_d = 1'b0;
`endif
                end
            end

            SERVE_I, SERVE_D: begin
                // Command held constant until completion; only the strobes
                // drop so the memory never sees a command across a resp.
                if (mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

    // A resp arriving while IDLE belongs to nobody and is dropped here.
    assign i_resp  = mem_resp & (state_q == SERVE_I);
    assign d_resp  = mem_resp & (state_q == SERVE_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
